alt_pattern_serializer: RTL and testbench
=========================================

Name: alt_pattern_serializer

Overview:
- Transmit-side counterpart of the task210 alternating-pattern detector.
- Accepts parallel WORD_W-bit words over a valid/ready handshake and shifts each one out MSB-first on a single serial line, holding each bit for DIV clocks.
- Flags whether the accepted word is an alternating pattern (every adjacent bit pair differs; 010 and 101 for WORD_W=3).
- Sits upstream of the serial detector as its stimulus source in Task210 signal-manipulation exercises.

Parameters:
- WORD_W, 3, word width in bits (legal range 2..16).
- DIV, 4, clock cycles per serial bit (legal range 1..255).

Ports:
- clk  in  1  single system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- din  in  WORD_W  parallel word to transmit.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a word this cycle.
- sout  out  1  serial data, MSB first.
- sframe  out  1  high while the first bit of a frame is on sout.
- sbusy  out  1  high while a frame is being shifted.
- done  out  1  one-cycle pulse when the frame completes.
- pattern_flag  out  1  registered alternating-pattern flag of the last accepted word.

Behaviour:
- Reset values, applied at the clk edge while reset=1: state=IDLE, sout=0, sframe=0, sbusy=0, done=0, pattern_flag=0, shift register=0, counters=0. din_ready=0 while reset=1.
- States:
  - IDLE: din_ready=1, sout=0. On din_valid&&din_ready at edge N: load shift register, set pattern_flag = AND over i of (din[i]^din[i+1]), go to SHIFT.
  - SHIFT: entered at cycle N+1. sout = shift register MSB. A div counter counts 0..DIV-1. At DIV-1, shift left and increment the bit counter. After bit WORD_W-1 completes, go to PARITY if the feature is enabled, otherwise go to IDLE.
  - PARITY: sout = parity bit for DIV cycles, then go to IDLE.
- Outputs and timing:
  - sbusy=1 in SHIFT and PARITY only.
  - sframe=1 for exactly the DIV cycles of bit 0.
  - done=1 for the single cycle in which the state returns to IDLE. din_ready is also 1 in that cycle, so back-to-back frames are possible with one IDLE cycle between them.
  - Frame length is WORD_W*DIV cycles (plus DIV with parity). done is asserted at cycle N+1+WORD_W*DIV (plus DIV with parity).
- din is ignored outside the handshake cycle. din_valid while busy is ignored; the word is not queued.
- pattern_flag holds its value until the next accept. It is computed combinationally from din, so it is valid from cycle N+1.
- Reset asserted mid-frame aborts immediately: all outputs return to reset values on the next edge and no done pulse is issued.
- DIV=1: sout changes every cycle.
- Counters are sized $clog2 of their range plus 1. They must not wrap within a frame.

Optional Feature:
- Macro ALT_SER_PARITY_EN.
- Defined: after the data bits, one extra even-parity bit (XOR of the accepted word) is sent for DIV cycles before done.
- Undefined: there is no PARITY state and the frame is data bits only.

Decomposition:
- Shared package alt_ser_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - a constant function is_alternating(word) used by both this block and its bench.
- One natural sub-module is bit_timer: a DIV-cycle counter with a tick output, reused by the serial detector.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → sout=0, sbusy=0, din_ready=0 during reset, din_ready=1 afterwards.
- Send din=3'b010, DIV=4 → sout = 0,1,0, each held 4 cycles; sframe high for cycles 1-4; done pulses at cycle 13 after accept; pattern_flag=1.
- Send din=3'b011 → sout = 0,1,1; pattern_flag=0. Then send 3'b101 → pattern_flag=1.
- Back-to-back: din_valid held high with 3'b110 then 3'b001 → exactly one cycle with din_ready=1 (the done cycle) between frames; no word is dropped or repeated.
- Reset at cycle 6 of a 3'b111 frame → sout=0, sbusy=0 on the next edge, no done pulse; the next frame 3'b100 transmits correctly.
- With ALT_SER_PARITY_EN, send 3'b011 → the 4th bit is 0, held 4 cycles; done at cycle 17.

Source files
------------

// File: rtl/alt_pattern_serializer_pkg.sv
// alt_ser_pkg: shared definitions for the alternating-pattern serializer
// and its matching serial detector.
// Holds the frame state encoding and the word classification helpers.
package alt_ser_pkg;

    // Widest word any user of this package may hand to the helpers.
    localparam int MAX_WORD_W = 16;

    // Frame states. PARITY is only reachable when the parity bit is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    // True when every adjacent bit pair in the low 'width' bits differs,
    // e.g. 010 and 101 for a 3-bit word.
    function automatic logic is_alternating(input logic [MAX_WORD_W-1:0] word,
                                            input int                    width);
        logic result;
        result = 1'b1;
        for (int i = 0; i < MAX_WORD_W - 1; i++) begin
            if (i < width - 1) begin
                result = result & (word[i] ^ word[i+1]);
            end
        end
        return result;
    endfunction

    // Even-parity bit of a word: XOR of all its bits (upper bits must be zero).
    function automatic logic even_parity(input logic [MAX_WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/alt_pattern_serializer_bit_timer.sv
// bit_timer: counts DIV clocks per serial bit and raises 'tick' on the last
// clock of each bit period. Held at zero while 'en' is low so every frame
// starts on a fresh bit period. Shared with the serial detector.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running 0..DIV-1 counter while enabled, cleared otherwise.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/alt_pattern_serializer.sv
// alt_pattern_serializer: accepts WORD_W-bit words over valid/ready and
// shifts them out MSB-first on 'sout', each bit held for DIV clocks.
// Reports whether the accepted word is an alternating pattern.
// Build option: define ALT_SER_PARITY_EN to append one even-parity bit
// (XOR of the word) after the data bits.
module alt_pattern_serializer
    import alt_ser_pkg::*;
#(
    parameter int WORD_W = 3,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sframe,
    output logic              sbusy,
    output logic              done,
    output logic              pattern_flag
);

    localparam int             BCW      = $clog2(WORD_W) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

    ser_state_t        state;
    ser_state_t        state_next;
    logic [WORD_W-1:0] shreg;
    logic [BCW-1:0]    bit_cnt;
    logic              done_r;
    logic              pattern_r;
    logic              tick;
    logic              accept;
    logic              shift_en;
    logic              frame_end;
`ifdef ALT_SER_PARITY_EN
    logic              parity_r;
`endif

    // One bit period timer, running only while a frame is on the line.
    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, datapath strobes and the combinational outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift_en   = 1'b0;
        frame_end  = 1'b0;
        din_ready  = 1'b0;
        sout       = 1'b0;
        sframe     = 1'b0;
        sbusy      = 1'b0;

        case (state)
            IDLE: begin
                din_ready = !reset;
                if (din_valid && !reset) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sbusy  = 1'b1;
                sout   = shreg[WORD_W-1];
                sframe = (bit_cnt == '0);
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef ALT_SER_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        frame_end  = 1'b1;
`endif
                    end
                end
            end
`ifdef ALT_SER_PARITY_EN
            PARITY: begin
                sbusy = 1'b1;
                sout  = parity_r;
                if (tick) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word capture on accept, MSB-first shifting on each bit boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            pattern_r <= 1'b0;
        end else if (accept) begin
            shreg     <= din;
            bit_cnt   <= '0;
            pattern_r <= is_alternating(MAX_WORD_W'(din), WORD_W);
        end else if (shift_en) begin
            shreg   <= {shreg[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BCW'(1);
        end
    end

`ifdef ALT_SER_PARITY_EN
    // Parity of the accepted word, captured alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (accept) begin
            parity_r <= even_parity(MAX_WORD_W'(din));
        end
    end
`endif

    // Single-cycle completion pulse, lands on the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= frame_end;
        end
    end

    assign done         = done_r;
    assign pattern_flag = pattern_r;

endmodule

// File: tb/tb_alt_pattern_serializer.sv
// tb_alt_pattern_serializer: self-checking bench for alt_pattern_serializer.
// Follows ALT_SER_PARITY_EN when it is defined for the build.
module tb_alt_pattern_serializer;
    import alt_ser_pkg::*;

    localparam int WORD_W = 3;
    localparam int DIV    = 4;
`ifdef ALT_SER_PARITY_EN
    localparam int FRAME_LEN = (WORD_W + 1) * DIV;
`else
    localparam int FRAME_LEN = WORD_W * DIV;
`endif

    logic              clk;
    logic              reset;
    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              sout;
    logic              sframe;
    logic              sbusy;
    logic              done;
    logic              pattern_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WORD_W-1:0] din;
        logic              exp_flag;
        logic              exp_par;
    } vec_t;

    vec_t table_v[8];

    alt_pattern_serializer #(
        .WORD_W (WORD_W),
        .DIV    (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .sout         (sout),
        .sframe       (sframe),
        .sbusy        (sbusy),
        .done         (done),
        .pattern_flag (pattern_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a word alternates iff it equals ...0101 or ...1010.
    function automatic logic model_alternating(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] a;
        for (int i = 0; i < WORD_W; i++) a[i] = (i % 2 == 1);
        return (w == a) || (w == ~a);
    endfunction

    // Reference: even-parity bit is 1 when the count of ones is odd.
    function automatic logic model_parity(input logic [WORD_W-1:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < WORD_W; i++) ones += int'(w[i]);
        return (ones % 2) == 1;
    endfunction

    // Reference: line level at cycle c (1-based) of a frame carrying w.
    function automatic logic model_bit(input logic [WORD_W-1:0] w, input logic par, input int c);
        int idx;
        idx = (c - 1) / DIV;
        if (idx < WORD_W) return w[WORD_W-1-idx];
        return par;
    endfunction

    // Offer one word, then check every cycle of its frame and the done cycle.
    // Returns at the falling edge of the done cycle.
    task automatic apply_stimulus(input logic [WORD_W-1:0] w, input logic exp_flag,
                                  input logic exp_par, input bit hold_valid);
        int waited;
        waited = 0;
        while (din_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (din_ready !== 1'b1) begin
            check_output("ready_timeout", 32'(din_ready), 32'd1);
            return;
        end
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) begin
            din_valid = 1'b0;
            din       = WORD_W'($urandom);
        end
        for (int c = 1; c <= FRAME_LEN; c++) begin
            check_output($sformatf("sout[w=%b c=%0d]", w, c), 32'(sout), 32'(model_bit(w, exp_par, c)));
            check_output($sformatf("sframe[w=%b c=%0d]", w, c), 32'(sframe), 32'(c <= DIV));
            check_output($sformatf("sbusy[w=%b c=%0d]", w, c), 32'(sbusy), 32'd1);
            check_output($sformatf("done_early[w=%b c=%0d]", w, c), 32'(done), 32'd0);
            check_output($sformatf("ready_busy[w=%b c=%0d]", w, c), 32'(din_ready), 32'd0);
            if (c == 1) check_output($sformatf("flag_first[w=%b]", w), 32'(pattern_flag), 32'(exp_flag));
            @(negedge clk);
        end
        check_output($sformatf("done[w=%b]", w), 32'(done), 32'd1);
        check_output($sformatf("sbusy_end[w=%b]", w), 32'(sbusy), 32'd0);
        check_output($sformatf("ready_end[w=%b]", w), 32'(din_ready), 32'd1);
        check_output($sformatf("sout_end[w=%b]", w), 32'(sout), 32'd0);
        check_output($sformatf("flag_end[w=%b]", w), 32'(pattern_flag), 32'(exp_flag));
    endtask

    initial begin
        int gap;
        logic [WORD_W-1:0] w;

        table_v[0] = '{3'b010, 1'b1, 1'b1};
        table_v[1] = '{3'b011, 1'b0, 1'b0};
        table_v[2] = '{3'b101, 1'b1, 1'b0};
        table_v[3] = '{3'b110, 1'b0, 1'b0};
        table_v[4] = '{3'b001, 1'b0, 1'b1};
        table_v[5] = '{3'b111, 1'b0, 1'b1};
        table_v[6] = '{3'b100, 1'b0, 1'b1};
        table_v[7] = '{3'b000, 1'b0, 1'b0};

        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        $display("[TB] reset phase");
        @(negedge clk);
        check_output("ready_in_reset", 32'(din_ready), 32'd0);
        @(negedge clk);
        check_output("rst_sout", 32'(sout), 32'd0);
        check_output("rst_sbusy", 32'(sbusy), 32'd0);
        check_output("rst_sframe", 32'(sframe), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_flag", 32'(pattern_flag), 32'd0);
        check_output("rst_ready", 32'(din_ready), 32'd0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_output("idle_ready", 32'(din_ready), 32'd1);
            check_output("idle_sbusy", 32'(sbusy), 32'd0);
        end

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("pkg_is_alternating[%b]", table_v[i].din),
                         32'(is_alternating(MAX_WORD_W'(table_v[i].din), WORD_W)),
                         32'(table_v[i].exp_flag));
            apply_stimulus(table_v[i].din, table_v[i].exp_flag, table_v[i].exp_par, 1'b0);
        end

        $display("[TB] back-to-back with din_valid held");
        apply_stimulus(3'b110, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3'b001, 1'b0, 1'b1, 1'b1);
        din_valid = 1'b0;
        @(negedge clk);
        check_output("b2b_no_repeat", 32'(sbusy), 32'd0);

        $display("[TB] reset mid-frame");
        din       = 3'b111;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_output("mid_busy", 32'(sbusy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_sout", 32'(sout), 32'd0);
        check_output("abort_sbusy", 32'(sbusy), 32'd0);
        check_output("abort_sframe", 32'(sframe), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_flag", 32'(pattern_flag), 32'd0);
        check_output("abort_ready", 32'(din_ready), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output($sformatf("abort_no_done[%0d]", k), 32'(done), 32'd0);
        end
        apply_stimulus(3'b100, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            w = WORD_W'($urandom);
            apply_stimulus(w, model_alternating(w), model_parity(w), bit'($urandom_range(0, 1)));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                din_valid = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    check_output("gap_idle", 32'(sbusy), 32'd0);
                end
            end
        end
        din_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
